// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: EX-stage issue/control unit sitting between the ID-stage
// register outputs and the MEM/WB path. Accepts one decoded op per
// valid/ready handshake and decodes ALUOp/funct into the 4-bit ALU control
// code. It drives registered operands to the ALU, then captures result/zero
// and resolves beq/bne.
// Optional build macro: ALU_ISSUE_ILLEGAL_EN adds illegal_o. When it is set,
// an illegal op returns a zero result and is never reported as taken.
module alu_issue_ctrl #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       aluop_i,
  input  logic [5:0]       funct_i,
  input  logic             alusrc_i,
  input  logic             branch_i,
  input  logic             bne_i,
  input  logic [DW-1:0]    rs_data_i,
  input  logic [DW-1:0]    rt_data_i,
  input  logic [DW-1:0]    imm_i,
  output logic [3:0]       alu_ctrl_o,
  output logic [DW-1:0]    alu_src1_o,
  output logic [DW-1:0]    alu_src2_o,
  input  logic [DW-1:0]    alu_result_i,
  input  logic             alu_zero_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [DW-1:0]    result_o,
  output logic             taken_o,
  output logic [CNT_W-1:0] op_cnt_o
`ifdef ALU_ISSUE_ILLEGAL_EN
  ,
  output logic             illegal_o
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;
  localparam logic [3:0] CTRL_ILL = 4'b1111;

  state_t     state;
  logic       accept;
  logic [3:0] dec_ctrl;
  logic       branch_q;
  logic       bne_q;
  logic       taken_raw;
`ifdef ALU_ISSUE_ILLEGAL_EN
  logic       illegal_q;
`endif

  // Ready is combinational so DONE can hand off a result and accept the next op in one edge
  always_comb begin
    ready_o = (state == IDLE) || ((state == DONE) && res_ready_i);
    accept  = valid_i && ready_o;
  end

  // Map ALUOp/funct to the ALU control code; unknown encodings become 1111
  always_comb begin
    dec_ctrl = CTRL_ILL;
    unique case (aluop_i)
      3'b010: begin
        unique case (funct_i)
          6'b100000: dec_ctrl = CTRL_ADD;
          6'b100010: dec_ctrl = CTRL_SUB;
          6'b100100: dec_ctrl = CTRL_AND;
          6'b100101: dec_ctrl = CTRL_OR;
          6'b101010: dec_ctrl = CTRL_SLT;
          6'b100111: dec_ctrl = CTRL_NOR;
          default:   dec_ctrl = CTRL_ILL;
        endcase
      end
      3'b000:  dec_ctrl = CTRL_ADD;
      3'b001:  dec_ctrl = CTRL_SUB;
      3'b011:  dec_ctrl = CTRL_SLT;
      3'b100:  dec_ctrl = CTRL_OR;
      default: dec_ctrl = CTRL_ILL;
    endcase
  end

  // beq resolves taken on zero, bne on non-zero; non-branch ops are never taken
  always_comb begin
    taken_raw = branch_q && (bne_q ? !alu_zero_i : alu_zero_i);
  end

  // Capture the accepted op directly into the ALU-facing registers.
  // These registers hold their value until the next accept.
  // Operand select and decode happen before the register, not after it.
  // The ALU therefore sees stable inputs for the whole EXEC cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      alu_ctrl_o <= '0;
      alu_src1_o <= '0;
      alu_src2_o <= '0;
      branch_q   <= 1'b0;
      bne_q      <= 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_EN
      illegal_q  <= 1'b0;
`endif
    end else if (accept) begin
      alu_ctrl_o <= dec_ctrl;
      alu_src1_o <= rs_data_i;
      alu_src2_o <= alusrc_i ? imm_i : rt_data_i;
      branch_q   <= branch_i;
      bne_q      <= bne_i;
`ifdef ALU_ISSUE_ILLEGAL_EN
      illegal_q  <= (dec_ctrl == CTRL_ILL);
`endif
    end
  end

  // Issue FSM: one EXEC cycle, then DONE holds the result until downstream takes it
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      res_valid_o <= 1'b0;
      result_o    <= '0;
      taken_o     <= 1'b0;
      op_cnt_o    <= '0;
`ifdef ALU_ISSUE_ILLEGAL_EN
      illegal_o   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) state <= EXEC;
        end
        EXEC: begin
          state       <= DONE;
          res_valid_o <= 1'b1;
`ifdef ALU_ISSUE_ILLEGAL_EN
          result_o    <= illegal_q ? '0 : alu_result_i;
          taken_o     <= !illegal_q && taken_raw;
          illegal_o   <= illegal_q;
`else
          result_o    <= alu_result_i;
          taken_o     <= taken_raw;
`endif
        end
        DONE: begin
          if (res_ready_i) begin
            res_valid_o <= 1'b0;
            op_cnt_o    <= op_cnt_o + 1'b1;
`ifdef ALU_ISSUE_ILLEGAL_EN
            illegal_o   <= 1'b0;
`endif
            state       <= valid_i ? EXEC : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
